// File: rtl/parity_sequencer_if.sv
// Bundle between the parity sequencer and its page memories / parity stage.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface parity_sequencer_if #(
  parameter int AW = 6
) ();
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [24:0]   rd_data;
  logic [24:0]   cur_page;
  logic [24:0]   prev_page;
  logic          cal_start;
  logic          cal_finish;
  logic [24:0]   parity_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [24:0]   wr_data;

  modport master (
    input  start, rd_data, cal_finish, parity_out,
    output busy, done, rd_addr, cur_page, prev_page, cal_start,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, cal_finish, parity_out,
    input  busy, done, rd_addr, cur_page, prev_page, cal_start,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/parity_sequencer.sv
// Streams pages from a synchronous-read memory, pairs each with its predecessor
// (page 0 with the last page), launches one parity calculation per page and stores the result.
module parity_sequencer #(
  parameter int PAGES = 64,
  parameter int AW    = 6
) (
  input  logic               clk,
  input  logic               rst,
  parity_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LAST,
    S_LD_PREV,
    S_RD_CUR,
    S_LD_CUR,
    S_CALC,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(PAGES - 1);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_wr_addr;
  logic [24:0]   r_cur_page;
  logic [24:0]   r_prev_page;
  logic [24:0]   r_wr_data;
  logic          r_busy;
  logic          r_done;
  logic          r_cal_start;
  logic          r_wr_en;
  logic          w_last_page;

  assign w_last_page = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_cur_page  <= '0;
      r_prev_page <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cal_start <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      // Strobes are set on the transition into their state so they are high for exactly that state.
      r_done      <= 1'b0;
      r_cal_start <= 1'b0;
      r_wr_en     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rd_addr <= LAST_IDX;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RD_LAST;
          end
        end
        S_RD_LAST: r_state <= S_LD_PREV;
        S_LD_PREV: begin
          r_prev_page <= bus.rd_data;
          r_rd_addr   <= r_idx;
          r_state     <= S_RD_CUR;
        end
        S_RD_CUR: r_state <= S_LD_CUR;
        S_LD_CUR: begin
          r_cur_page  <= bus.rd_data;
          r_cal_start <= 1'b1;
          r_state     <= S_CALC;
        end
        S_CALC: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.cal_finish) begin
            r_wr_data <= bus.parity_out;
            r_wr_addr <= r_idx;
            r_wr_en   <= 1'b1;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The current page becomes the predecessor of the next one, saving a re-read.
          r_prev_page <= r_cur_page;
          if (w_last_page) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx     <= r_idx + 1'b1;
            r_rd_addr <= r_idx + 1'b1;
            r_state   <= S_RD_CUR;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.cur_page  = r_cur_page;
  assign bus.prev_page = r_prev_page;
  assign bus.cal_start = r_cal_start;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;

endmodule

// File: tb/tb_parity_sequencer.sv
// Bench for parity_sequencer: a 64-page and a 1-page instance, page memory and
// parity-stage models, and a scoreboard of expected launches and writes per run.
module tb_parity_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parity_sequencer_if #(.AW(6)) b_if ();
  parity_sequencer_if #(.AW(1)) s_if ();

  parity_sequencer #(.PAGES(64), .AW(6)) dut_big (.clk(clk), .rst(rst), .bus(b_if.master));
  parity_sequencer #(.PAGES(1),  .AW(1)) dut_one (.clk(clk), .rst(rst), .bus(s_if.master));

  logic        sel = 1'b0;
  logic        start_drv = 1'b0;
  logic        spur = 1'b0;
  int          w_cfg = 1;
  int          wcnt_big = 0;
  int          wcnt_one = 0;
  logic [24:0] mem_big [64];
  logic [24:0] mem_one = 25'h1ABCDEF;
  int          checks = 0;
  int          errors = 0;

  assign b_if.start = start_drv & ~sel;
  assign s_if.start = start_drv & sel;

  always @(posedge clk) begin
    b_if.rd_data <= mem_big[b_if.rd_addr];
    s_if.rd_data <= (s_if.rd_addr == 1'b0) ? mem_one : 25'h0;
  end

  // Parity stage: finishes on the w_cfg-th WAIT cycle; optionally also pulses during CALC.
  always @(posedge clk) begin
    if (rst) wcnt_big <= 0;
    else if (b_if.cal_start) wcnt_big <= w_cfg;
    else if (wcnt_big > 0) wcnt_big <= wcnt_big - 1;
    if (rst) wcnt_one <= 0;
    else if (s_if.cal_start) wcnt_one <= w_cfg;
    else if (wcnt_one > 0) wcnt_one <= wcnt_one - 1;
  end
  assign b_if.cal_finish = (wcnt_big == 1) | (spur & b_if.cal_start);
  assign s_if.cal_finish = (wcnt_one == 1) | (spur & s_if.cal_start);
  assign b_if.parity_out = b_if.cur_page ^ b_if.prev_page;
  assign s_if.parity_out = s_if.cur_page ^ s_if.prev_page;

  wire        m_busy      = sel ? s_if.busy      : b_if.busy;
  wire        m_done      = sel ? s_if.done      : b_if.done;
  wire        m_cal_start = sel ? s_if.cal_start : b_if.cal_start;
  wire        m_wr_en     = sel ? s_if.wr_en     : b_if.wr_en;
  wire [5:0]  m_rd_addr   = sel ? {5'd0, s_if.rd_addr} : b_if.rd_addr;
  wire [5:0]  m_wr_addr   = sel ? {5'd0, s_if.wr_addr} : b_if.wr_addr;
  wire [24:0] m_wr_data   = sel ? s_if.wr_data   : b_if.wr_data;
  wire [24:0] m_cur       = sel ? s_if.cur_page  : b_if.cur_page;
  wire [24:0] m_prev      = sel ? s_if.prev_page : b_if.prev_page;

  typedef struct {
    int          addr;
    logic [24:0] data;
    logic [24:0] prev;
    logic [24:0] cur;
    int          cal_cyc;
    int          wr_cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string name;
    logic  s;
    int    w;
    logic  sp;
    int    spst;
    int    exp_done;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, " busy"},      {31'd0, m_busy},      32'd0);
    check({name, " done"},      {31'd0, m_done},      32'd0);
    check({name, " cal_start"}, {31'd0, m_cal_start}, 32'd0);
    check({name, " wr_en"},     {31'd0, m_wr_en},     32'd0);
    check({name, " rd_addr"},   {26'd0, m_rd_addr},   32'd0);
    check({name, " wr_addr"},   {26'd0, m_wr_addr},   32'd0);
    check({name, " wr_data"},   {7'd0, m_wr_data},    32'd0);
    check({name, " cur_page"},  {7'd0, m_cur},        32'd0);
    check({name, " prev_page"}, {7'd0, m_prev},       32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after done.
  task automatic run(input string name, input logic s, input int w, input logic sp,
                     input int spst, input int abort_at, input int exp_done);
    int   pages;
    int   c;
    int   writes;
    int   cals;
    bit   in_calc;
    exp_t e;
    pages = s ? 1 : 64;
    sel   = s;
    w_cfg = w;
    spur  = sp;
    sbq.delete();
    for (int k = 0; k < pages; k++) begin
      e.addr    = k;
      e.cur     = s ? mem_one : mem_big[k];
      e.prev    = s ? mem_one : mem_big[(k + pages - 1) % pages];
      e.data    = e.cur ^ e.prev;
      e.cal_cyc = 5 + k * (4 + w);
      e.wr_cyc  = 2 + (k + 1) * (4 + w);
      sbq.push_back(e);
    end
    writes  = 0;
    cals    = 0;
    in_calc = 0;
    start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_drv = 1'b0;
    c = 1;
    while (c < 3000) begin
      if (spst > 0) start_drv = (c == spst) || (c == spst + 90);
      if (abort_at > 0 && c == abort_at) begin
        rst = 1'b1;
        #1;
        check_zero({name, " async reset"});
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (i == 3) rst = 1'b0;
          check({name, " wr_en after reset"}, {31'd0, m_wr_en}, 32'd0);
          check({name, " busy after reset"},  {31'd0, m_busy},  32'd0);
        end
        $display("%s aborted by reset at cycle %0d after %0d writes", name, c, writes);
        sbq.delete();
        return;
      end
      check({name, " busy"}, {31'd0, m_busy}, {31'd0, (c <= exp_done)});
      check({name, " done"}, {31'd0, m_done}, {31'd0, (c == exp_done)});
      if (m_cal_start) begin
        cals++;
        in_calc = 1;
        if (sbq.size() == 0) check({name, " unexpected cal_start"}, c, 32'd0);
        else check({name, " cal_start cycle"}, c, sbq[0].cal_cyc);
      end
      if (in_calc && sbq.size() > 0) begin
        check({name, " cur_page"},  {7'd0, m_cur},  {7'd0, sbq[0].cur});
        check({name, " prev_page"}, {7'd0, m_prev}, {7'd0, sbq[0].prev});
      end
      if (m_wr_en) begin
        writes++;
        in_calc = 0;
        if (sbq.size() == 0) check({name, " unexpected wr_en"}, c, 32'd0);
        else begin
          e = sbq.pop_front();
          check({name, " wr_addr"},  {26'd0, m_wr_addr}, e.addr);
          check({name, " wr_data"},  {7'd0, m_wr_data}, {7'd0, e.data});
          check({name, " wr_cycle"}, c, e.wr_cyc);
          $display("%s write addr=%0d data=%h cycle=%0d", name, m_wr_addr, m_wr_data, c);
        end
      end
      if (c == exp_done + 1) begin
        check({name, " write count"},    writes, pages);
        check({name, " cal_start count"}, cals, pages);
        check({name, " leftover"},       sbq.size(), 0);
        return;
      end
      @(negedge clk);
      c++;
    end
    check({name, " timeout waiting for done"}, c, exp_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 64; j++) mem_big[j] = 25'(j);
    vecs[0] = '{name: "basic",    s: 1'b0, w: 1, sp: 1'b0, spst: 0,  exp_done: 323};
    vecs[1] = '{name: "slow",     s: 1'b0, w: 3, sp: 1'b0, spst: 0,  exp_done: 451};
    vecs[2] = '{name: "spurious", s: 1'b0, w: 1, sp: 1'b1, spst: 10, exp_done: 323};
    vecs[3] = '{name: "wrap",     s: 1'b1, w: 1, sp: 1'b0, spst: 0,  exp_done: 8};

    repeat (3) @(negedge clk);
    sel = 1'b0;
    #1 check_zero("reset big");
    sel = 1'b1;
    #1 check_zero("reset one");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run(vecs[v].name, vecs[v].s, vecs[v].w, vecs[v].sp, vecs[v].spst, 0, vecs[v].exp_done);
      repeat (3) @(negedge clk);
    end

    run("midreset", 1'b0, 1, 1'b0, 0, 50, 323);
    repeat (2) @(negedge clk);
    run("after_reset", 1'b0, 1, 1'b0, 0, 0, 323);
    repeat (3) @(negedge clk);

    run("b2b_first",  1'b0, 1, 1'b0, 0, 0, 323);
    run("b2b_second", 1'b0, 1, 1'b0, 0, 0, 323);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_sequencer.md
# parity_sequencer

Sequencing stage directly upstream of the encoder's `parity` block. It streams the 25-bit state pages from a synchronous-read page memory and presents each page with its predecessor as `cur_page`/`prev_page`. It launches one parity calculation per page with a `cal_start`/`cal_finish` handshake and writes each 25-bit parity result to an output page memory. Page 0 is paired with the last page, so the page index wraps around.

## Interface

Parameters:
- `PAGES`, default 64: number of pages processed per run; must be ≥1.
- `AW`, default 6: address width; 2^AW ≥ PAGES.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to process all pages; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last page result is written.
- `rd_addr`  out  AW  page-memory read address (registered).
- `rd_data`  in  25  page-memory data, valid the cycle after `rd_addr` is applied.
- `cur_page`  out  25  page i to the parity stage (registered).
- `prev_page`  out  25  page (i−1) mod PAGES to the parity stage (registered).
- `cal_start`  out  1  one-cycle launch pulse to the parity stage.
- `cal_finish`  in  1  parity stage completion; sampled only in WAIT.
- `parity_out`  in  25  parity result, valid while `cal_finish` is high.
- `wr_en`  out  1  one-cycle write strobe to the output memory.
- `wr_addr`  out  AW  output-memory write address.
- `wr_data`  out  25  parity result being written (registered).

## Operation

- State machine: IDLE, RD_LAST, LD_PREV, RD_CUR, LD_CUR, CALC, WAIT, WRITE, DONE.
- **IDLE:** outputs held. `start`=1 sets `rd_addr`=PAGES−1, clears the page counter i, and moves to RD_LAST.
- **RD_LAST:** memory access cycle. Moves to LD_PREV.
- **LD_PREV:** `prev_page`←`rd_data`, `rd_addr`←i. Moves to RD_CUR.
- **RD_CUR:** memory access cycle. Moves to LD_CUR.
- **LD_CUR:** `cur_page`←`rd_data`. Moves to CALC.
- **CALC:** `cal_start`=1 for exactly this cycle. Moves to WAIT.
- **WAIT:** stays in WAIT while `cal_finish`=0. When `cal_finish`=1, `wr_data`←`parity_out` and `wr_addr`←i, then moves to WRITE.
- **WRITE:** `wr_en`=1 for exactly this cycle, `prev_page`←`cur_page`.
  - If i=PAGES−1, moves to DONE.
  - Otherwise i←i+1, `rd_addr`←i+1, and moves to RD_CUR.
- **DONE:** `done`=1 for one cycle. Moves to IDLE.
- Wrap-around: page 0 is paired with page PAGES−1. When PAGES=1, page 0 is paired with itself.
- `cur_page` and `prev_page` are stable from CALC through WRITE inclusive.
- `start` outside IDLE is ignored and has no queued effect.
- `cal_finish` in CALC, or in any state other than WAIT, is ignored.
- Counter width is AW. i never exceeds PAGES−1.

## Timing

- Reset values while `rst`=1 and after its release:
  - state IDLE, i=0;
  - `busy`=0, `done`=0, `cal_start`=0, `wr_en`=0;
  - `rd_addr`, `wr_addr`, `wr_data`, `cur_page`, `prev_page` all 0.
- Reset mid-run aborts immediately. No further `wr_en` is issued, and the block waits in IDLE for a new `start`.
- Cycle numbering: cycle 0 is the edge sampling `start`. RD_LAST is cycle 1, LD_PREV is cycle 2.
- With W WAIT cycles per page (W≥1, the `cal_finish` cycle included), each page takes 4+W cycles.
- `cal_start` for page k falls in cycle 5+k(4+W).
- `wr_en` for page k falls in cycle 2+(k+1)(4+W).
- `done` falls in cycle 3+PAGES(4+W).
- Minimum W=1 gives 5 cycles per page. With PAGES=64, `done` falls in cycle 323.
- `busy` rises in cycle 1 and falls when the block returns to IDLE, the cycle after `done`.

## Test plan

- **Basic run:** PAGES=64, memory page j = j, parity model asserts `cal_finish` on the first WAIT cycle with `parity_out` = cur^prev.
  - First `cal_start`: prev=63, cur=0.
  - Write to addr 0 carries data 63.
  - Write to addr 63 carries data 63^62.
  - `done` in cycle 323, exactly 64 `wr_en` pulses.
- **Slow parity stage:** `cal_finish` is delayed to the third WAIT cycle (W=3).
  - Per-page period is 7 cycles.
  - `done` in cycle 451.
  - `cur_page`/`prev_page` stay stable throughout WAIT.
- **Spurious inputs:**
  - `start` pulsed in cycles 10 and 100 during a run → no restart, `wr_addr` sequence unchanged.
  - `cal_finish` held high during CALC → ignored; each page still shows one `cal_start` and one `wr_en`.
- **Reset mid-run:** `rst` asserted in cycle 50.
  - All outputs are 0 asynchronously.
  - No `wr_en` after reset.
  - A fresh `start` reproduces the full basic-run sequence.
- **Wrap boundary:** PAGES=1, page 0 = 25'h1ABCDEF.
  - `cal_start` shows prev=cur=25'h1ABCDEF.
  - One write to addr 0.
  - `done` in cycle 8 with W=1.
- **Back-to-back runs:** `start` applied the cycle after `busy` falls.
  - The second run's timing is identical to the first.
